demux_1_a_4: RTL and testbench

Registered 1-to-4 demultiplexer with valid/ready flow control. It is the inverse companion of the 4-to-1 MUX. It accepts one WIDTH-bit word per transfer together with a 2-bit select, and steers the word into a one-entry holding slot on output channel a, b, c or d. Each channel is drained independently by its own consumer. It sits between a single producer and four downstream consumers, for example the reconstruction side of a multiplexed 4-bit lane.

---
 rtl/demux_pkg.sv | 9 +
 rtl/demux_slot.sv | 53 +++++
 rtl/demux_1_a_4.sv | 63 ++++++
 tb/tb_demux_1_a_4.sv | 116 +++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants for the 1-to-4 demultiplexer
package demux_pkg;
   localparam logic [1:0] CH_A = 2'b00;
   localparam logic [1:0] CH_B = 2'b01;
   localparam logic [1:0] CH_C = 2'b10;
   localparam logic [1:0] CH_D = 2'b11;
   localparam int NUM_CH = 4;
   localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding slot with full flag and fill/drain handshake; counter when DEMUX_COUNT_EN is defined
module demux_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_fill,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
`ifdef DEMUX_COUNT_EN
   ,
   output logic [CNT_W-1:0] o_cnt
`endif
);
   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;
   // a fill wins over a same-cycle drain so the slot passes words through at full rate
   always_comb begin
      full_d = i_fill | (full_q & ~i_ready);
      data_d = i_fill ? i_data : data_q;
   end
   // slot state; reset drops any held word
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end
   assign o_valid = full_q;
   assign o_data  = data_q;
`ifdef DEMUX_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // count accepted words, wrapping naturally at all-ones
   always_comb cnt_d = i_fill ? cnt_q + 1'b1 : cnt_q;
   // counter register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign o_cnt = cnt_q;
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif
endmodule

// File: rtl/demux_1_a_4.sv
// demux_1_a_4: registered 1-to-4 demux with valid/ready; DEMUX_COUNT_EN adds per-channel transfer counters
module demux_1_a_4
   import demux_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [WIDTH-1:0]  i_data,
   input  logic [1:0]        i_sel,
   input  logic              i_valid,
   output logic              o_ready,
   output logic [WIDTH-1:0]  o_a,
   output logic [WIDTH-1:0]  o_b,
   output logic [WIDTH-1:0]  o_c,
   output logic [WIDTH-1:0]  o_d,
   output logic [NUM_CH-1:0] o_valid,
   input  logic [NUM_CH-1:0] i_ready
`ifdef DEMUX_COUNT_EN
   ,
   output logic [CNT_W-1:0]  o_cnt_a,
   output logic [CNT_W-1:0]  o_cnt_b,
   output logic [CNT_W-1:0]  o_cnt_c,
   output logic [CNT_W-1:0]  o_cnt_d
`endif
);
   logic [NUM_CH-1:0] fill;
   logic [WIDTH-1:0]  data [NUM_CH];
`ifdef DEMUX_COUNT_EN
   logic [CNT_W-1:0]  cnt [NUM_CH];
`endif
   // accept when the selected slot is empty or draining; steer the transfer to that slot only
   always_comb begin
      o_ready = ~o_valid[i_sel] | i_ready[i_sel];
      fill    = (i_valid & o_ready) ? NUM_CH'(1) << i_sel : '0;
   end
   for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
      demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_fill  (fill[g]),
         .i_data  (i_data),
         .i_ready (i_ready[g]),
         .o_valid (o_valid[g]),
         .o_data  (data[g])
`ifdef DEMUX_COUNT_EN
         ,
         .o_cnt   (cnt[g])
`endif
      );
   end
   assign o_a = data[CH_A];
   assign o_b = data[CH_B];
   assign o_c = data[CH_C];
   assign o_d = data[CH_D];
`ifdef DEMUX_COUNT_EN
   assign o_cnt_a = cnt[CH_A];
   assign o_cnt_b = cnt[CH_B];
   assign o_cnt_c = cnt[CH_C];
   assign o_cnt_d = cnt[CH_D];
`endif
endmodule

// File: tb/tb_demux_1_a_4.sv
// tb_demux_1_a_4: directed plus random stimulus against a slot-level reference model
module tb_demux_1_a_4;
   localparam int W = 4;
   localparam int CW = 8;
   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic [W-1:0]  i_data;
   logic [1:0]    i_sel;
   logic          i_valid;
   logic          o_ready;
   logic [W-1:0]  o_a, o_b, o_c, o_d;
   logic [3:0]    o_valid;
   logic [3:0]    i_ready;
`ifdef DEMUX_COUNT_EN
   logic [CW-1:0] o_cnt_a, o_cnt_b, o_cnt_c, o_cnt_d;
`endif
   int checks = 0;
   int failures = 0;
   bit           m_full [4];
   logic [W-1:0] m_data [4];
   int           m_cnt  [4];
   always #5 i_clk = ~i_clk;
   demux_1_a_4 #(.WIDTH(W), .CNT_W(CW)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_data  (i_data),
      .i_sel   (i_sel),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_a     (o_a),
      .o_b     (o_b),
      .o_c     (o_c),
      .o_d     (o_d),
      .o_valid (o_valid),
      .i_ready (i_ready)
`ifdef DEMUX_COUNT_EN
      ,
      .o_cnt_a (o_cnt_a),
      .o_cnt_b (o_cnt_b),
      .o_cnt_c (o_cnt_c),
      .o_cnt_d (o_cnt_d)
`endif
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   // one clock: drive, check o_ready mid-cycle, advance model at the edge, check registered outputs
   task automatic cycle(input bit rst_n, input bit v, input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] r);
      bit acc;
      logic [3:0] exp_v;
      i_rst_n = rst_n; i_valid = v; i_sel = s; i_data = d; i_ready = r;
      #2;
      acc = !m_full[s] || r[s];
      if (rst_n) chk("o_ready", o_ready, acc);
      @(posedge i_clk);
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin m_full[k] = 0; m_data[k] = '0; m_cnt[k] = 0; end
      end else begin
         for (int k = 0; k < 4; k++) if (m_full[k] && r[k]) m_full[k] = 0;
         if (v && acc) begin
            m_full[s] = 1; m_data[s] = d; m_cnt[s] = (m_cnt[s] + 1) % (1 << CW);
         end
      end
      #1;
      for (int k = 0; k < 4; k++) exp_v[k] = m_full[k];
      chk("o_valid", o_valid, exp_v);
      chk("o_a", o_a, m_data[0]);
      chk("o_b", o_b, m_data[1]);
      chk("o_c", o_c, m_data[2]);
      chk("o_d", o_d, m_data[3]);
`ifdef DEMUX_COUNT_EN
      chk("o_cnt_a", o_cnt_a, m_cnt[0]);
      chk("o_cnt_b", o_cnt_b, m_cnt[1]);
      chk("o_cnt_c", o_cnt_c, m_cnt[2]);
      chk("o_cnt_d", o_cnt_d, m_cnt[3]);
`endif
   endtask
   initial begin
      for (int k = 0; k < 4; k++) begin m_full[k] = 0; m_data[k] = '0; m_cnt[k] = 0; end
      @(negedge i_clk);
      cycle(0, 1, 2'b00, 4'hF, 4'b1111);
      cycle(0, 1, 2'b11, 4'hF, 4'b0000);
      chk("rst_valid", o_valid, 4'b0000);
      i_rst_n = 1; i_valid = 0; #1;
      chk("rst_ready", o_ready, 1);
      cycle(1, 1, 2'b00, 4'h1, 4'b0000);
      chk("route_a", o_a, 4'h1);
      cycle(1, 1, 2'b01, 4'h2, 4'b0000);
      cycle(1, 1, 2'b10, 4'h3, 4'b0000);
      cycle(1, 1, 2'b11, 4'h4, 4'b0000);
      chk("route_all", {o_valid, o_a, o_b, o_c, o_d}, 20'hF1234);
      cycle(1, 1, 2'b01, 4'h9, 4'b0000);
      chk("bp_hold", o_b, 4'h2);
      cycle(1, 1, 2'b01, 4'h9, 4'b0010);
      chk("bp_pass", {o_valid[1], o_b}, 5'h19);
      cycle(1, 1, 2'b11, 4'h5, 4'b1000);
      cycle(1, 1, 2'b11, 4'h6, 4'b1000);
      cycle(1, 1, 2'b11, 4'h7, 4'b1000);
      chk("indep", {o_a, o_d}, 8'h17);
      cycle(0, 0, 2'b00, 4'h0, 4'b0000);
      chk("mid_rst", o_valid, 4'b0000);
`ifdef DEMUX_COUNT_EN
      for (int n = 0; n < 257; n++) cycle(1, 1, 2'b10, W'(n), 4'b0100);
      chk("cnt_wrap", {o_cnt_a, o_cnt_b, o_cnt_c, o_cnt_d}, 32'h00000100);
`endif
      for (int n = 0; n < 3000; n++)
         cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), 2'($urandom),
               W'($urandom), 4'($urandom) & 4'($urandom | $urandom));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
